// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the IFU/LSU memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    // Master identifiers, also used as the round-robin history bit
    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    // Instruction fetches always move a full word
    localparam logic [3:0] WMASK_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : IFU, LSU and memory-side handshake bundle of the arbiter.
//                slave  = arbiter view, master = environment (masters + pmem).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IFU side
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    // LSU side
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_wen;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [3:0]        lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    // Memory side
    logic              mem_req_valid;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              bus_err;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output bus_err
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr2
//  Description : Two-input round-robin picker. Purely combinational; the
//                history bit (last grant) is owned by the caller.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_rr2
    import mem_arb_pkg::*;
(
    input  wire logic [1:0] i_req,   // [0] = IFU, [1] = LSU
    input  wire logic       i_last,  // master granted most recently
    output logic            o_grant  // winning master id
);

    // Single requester wins outright; a tie goes to whoever was not served last
    always_comb begin
        o_grant = MST_IFU;
        case (i_req)
            2'b01:   o_grant = MST_IFU;
            2'b10:   o_grant = MST_LSU;
            2'b11:   o_grant = (i_last == MST_IFU) ? MST_LSU : MST_IFU;
            default: o_grant = MST_IFU;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory port between IFU and LSU. One outstanding
//                transaction, round-robin on contention, response watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mem_arbiter_if.slave   bus
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    arb_state_t        r_state;
    logic              r_last;
    logic              r_owner;
    logic              r_mem_req_valid;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wmask;
    logic [7:0]        r_cnt;
    logic              r_ifu_resp;
    logic              r_lsu_resp;
    logic              r_bus_err;
    logic [DATA_W-1:0] r_ifu_rdata;
    logic [DATA_W-1:0] r_lsu_rdata;

    logic [1:0]        w_req;
    logic              w_grant;
    logic              w_accept;

    assign w_req = {bus.lsu_req_valid, bus.ifu_req_valid};

    arb_rr2 u_rr (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // A request is taken only while idle; ready is withheld during reset
    assign w_accept = (r_state == IDLE) && !reset && (w_req != 2'b00);

    assign bus.ifu_req_ready  = w_accept && (w_grant == MST_IFU);
    assign bus.lsu_req_ready  = w_accept && (w_grant == MST_LSU);
    assign bus.mem_req_valid  = r_mem_req_valid;
    assign bus.mem_wen        = r_wen;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_wmask      = r_wmask;
    assign bus.ifu_resp_valid = r_ifu_resp;
    assign bus.ifu_rdata      = r_ifu_rdata;
    assign bus.lsu_resp_valid = r_lsu_resp;
    assign bus.lsu_rdata      = r_lsu_rdata;
    assign bus.bus_err        = r_bus_err;

    // Transaction FSM: latch on accept, present to memory, await response or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_last          <= MST_IFU;
            r_owner         <= MST_IFU;
            r_mem_req_valid <= 1'b0;
            r_wen           <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            r_cnt           <= '0;
            r_ifu_resp      <= 1'b0;
            r_lsu_resp      <= 1'b0;
            r_bus_err       <= 1'b0;
            r_ifu_rdata     <= '0;
            r_lsu_rdata     <= '0;
        end else begin
            // Response and error flags are single-cycle pulses
            r_ifu_resp <= 1'b0;
            r_lsu_resp <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant;
                        r_last  <= w_grant;
                        if (w_grant == MST_LSU) begin
                            r_wen   <= bus.lsu_wen;
                            r_addr  <= bus.lsu_addr;
                            r_wdata <= bus.lsu_wdata;
                            r_wmask <= bus.lsu_wmask;
                        end else begin
                            r_wen   <= 1'b0;
                            r_addr  <= bus.ifu_addr;
                            r_wdata <= '0;
                            r_wmask <= WMASK_WORD;
                        end
                        r_mem_req_valid <= 1'b1;
                        r_state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= WAIT;
                    end
                end
                WAIT: begin
                    // A real response takes priority over the watchdog
                    if (bus.mem_resp_valid || (r_cnt == c_TIMEOUT)) begin
                        if (r_owner == MST_LSU) begin
                            r_lsu_resp  <= 1'b1;
                            r_lsu_rdata <= bus.mem_resp_valid ? bus.mem_rdata : '0;
                        end else begin
                            r_ifu_resp  <= 1'b1;
                            r_ifu_rdata <= bus.mem_resp_valid ? bus.mem_rdata : '0;
                        end
                        r_bus_err <= !bus.mem_resp_valid;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter with a transaction-level
//                reference model (round-robin history, held read data).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 = IFU served last, 1 = LSU served last
    bit          m_last  = 1'b0;
    logic [31:0] m_ifu_rd = '0;
    logic [31:0] m_lsu_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ifu_resp"}, 32'(bus.ifu_resp_valid), 32'd0);
        chk({tag, "_lsu_resp"}, 32'(bus.lsu_resp_valid), 32'd0);
        chk({tag, "_bus_err"},  32'(bus.bus_err), 32'd0);
    endtask

    // One full transaction; rs_d > TIMEOUT means memory never answers
    task automatic run_txn(input bit iv, input bit lv, input logic [31:0] ia,
                           input bit lw, input logic [31:0] la, input logic [31:0] ld,
                           input logic [3:0] lm, input int rq_d, input int rs_d,
                           input logic [31:0] rd);
        bit          win;
        bit          tmo;
        int          n_wait;
        logic [31:0] e_addr, e_wdata, e_rd;
        logic        e_wen;
        logic [3:0]  e_mask;
        // accept cycle
        @(negedge clk);
        bus.ifu_req_valid = iv;  bus.ifu_addr  = ia;
        bus.lsu_req_valid = lv;  bus.lsu_wen   = lw;  bus.lsu_addr = la;
        bus.lsu_wdata     = ld;  bus.lsu_wmask = lm;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        #1;
        win = (iv && lv) ? !m_last : lv;
        chk("acc_ifu_ready", 32'(bus.ifu_req_ready), 32'(iv && !win));
        chk("acc_lsu_ready", 32'(bus.lsu_req_ready), 32'(win));
        chk("acc_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        chk_quiet("acc");
        m_last = win;
        e_addr  = win ? la : ia;
        e_wen   = win ? lw : 1'b0;
        e_wdata = win ? ld : 32'd0;
        e_mask  = win ? lm : 4'hF;
        // request phase: upstream fields scrambled, stray responses injected
        for (int k = 0; k <= rq_d; k++) begin
            @(negedge clk);
            bus.ifu_req_valid = 1'($urandom_range(0, 1));
            bus.lsu_req_valid = 1'($urandom_range(0, 1));
            bus.ifu_addr  = $urandom; bus.lsu_addr = $urandom;
            bus.lsu_wdata = $urandom; bus.lsu_wen  = 1'($urandom_range(0, 1));
            bus.lsu_wmask = 4'($urandom);
            bus.mem_req_ready  = (k == rq_d);
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_rdata      = $urandom;
            #1;
            chk("req_mem_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("req_mem_addr",  bus.mem_addr, e_addr);
            chk("req_mem_wen",   32'(bus.mem_wen), 32'(e_wen));
            chk("req_mem_wdata", bus.mem_wdata, e_wdata);
            chk("req_mem_wmask", 32'(bus.mem_wmask), 32'(e_mask));
            chk("req_ready_lo",  32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'd0);
            chk_quiet("req");
        end
        // wait phase
        tmo    = (rs_d > TIMEOUT);
        n_wait = tmo ? TIMEOUT + 1 : rs_d + 1;
        for (int w = 0; w < n_wait; w++) begin
            @(negedge clk);
            bus.ifu_req_valid  = 1'($urandom_range(0, 1));
            bus.lsu_req_valid  = 1'($urandom_range(0, 1));
            bus.mem_req_ready  = 1'($urandom_range(0, 1));
            bus.mem_resp_valid = !tmo && (w == rs_d);
            bus.mem_rdata      = bus.mem_resp_valid ? rd : $urandom;
            #1;
            chk("wait_mem_valid", 32'(bus.mem_req_valid), 32'd0);
            chk("wait_ready_lo",  32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'd0);
            chk_quiet("wait");
        end
        // response cycle, with a stray memory response that must be ignored
        @(negedge clk);
        bus.ifu_req_valid  = 1'b0; bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'($urandom_range(0, 1));
        bus.mem_rdata      = $urandom;
        #1;
        e_rd = tmo ? 32'd0 : rd;
        if (win) m_lsu_rd = e_rd; else m_ifu_rd = e_rd;
        chk("rsp_ifu_valid", 32'(bus.ifu_resp_valid), 32'(!win));
        chk("rsp_lsu_valid", 32'(bus.lsu_resp_valid), 32'(win));
        chk("rsp_bus_err",   32'(bus.bus_err), 32'(tmo));
        chk("rsp_ifu_rdata", bus.ifu_rdata, m_ifu_rd);
        chk("rsp_lsu_rdata", bus.lsu_rdata, m_lsu_rd);
        chk("rsp_mem_valid", 32'(bus.mem_req_valid), 32'd0);
    endtask

    initial begin
        int r;
        bus.ifu_req_valid = 0; bus.ifu_addr = 0;
        bus.lsu_req_valid = 0; bus.lsu_wen = 0; bus.lsu_addr = 0;
        bus.lsu_wdata = 0; bus.lsu_wmask = 0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = 0;

        // reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_quiet("rst");
        chk("rst_ready",     32'({bus.ifu_req_ready, bus.lsu_req_ready}), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_addr",  bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        chk("rst_mem_wen",   32'(bus.mem_wen), 32'd0);
        chk("rst_ifu_rdata", bus.ifu_rdata, 32'd0);
        chk("rst_lsu_rdata", bus.lsu_rdata, 32'd0);

        // four ties in a row after reset: LSU, IFU, LSU, IFU
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, $urandom, 0, $urandom, $urandom, 4'hF, 0, 0, $urandom);

        // IFU read alone, best-case latency
        run_txn(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 32'h0010_0073);

        // byte store held through three cycles of back-pressure
        run_txn(0, 1, 0, 1, 32'h8000_0104, 32'h0000_00AB, 4'b0001, 3, 1, $urandom);

        // memory never answers: watchdog error response to the LSU
        run_txn(0, 1, 0, 0, 32'h8000_0200, 0, 4'hF, 0, TIMEOUT + 1, 0);

        // stray memory responses while idle
        repeat (3) begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b1; bus.mem_rdata = $urandom;
            #1;
            chk_quiet("stray");
            chk("stray_mem_valid", 32'(bus.mem_req_valid), 32'd0);
            chk("stray_ifu_rdata", bus.ifu_rdata, m_ifu_rd);
            chk("stray_lsu_rdata", bus.lsu_rdata, m_lsu_rd);
        end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        #1;
        chk_quiet("stray_post");

        // make IFU rdata non-zero so the reset clear is observable
        run_txn(1, 0, $urandom, 0, 0, 0, 0, 0, 0, 32'hCAFE_F00D);

        // reset in WAIT, then a late memory response
        @(negedge clk);
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0040;
        #1;
        chk("mid_ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        #1;
        chk("mid_mem_valid", 32'(bus.mem_req_valid), 32'd1);
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_last = 1'b0; m_ifu_rd = '0; m_lsu_rd = '0;
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            #1;
            chk_quiet("late");
            chk("late_mem_valid", 32'(bus.mem_req_valid), 32'd0);
            chk("late_ifu_rdata", bus.ifu_rdata, m_ifu_rd);
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
        end
        run_txn(1, 0, 32'h8000_0044, 0, 0, 0, 0, 1, 2, 32'h1234_5678);
        run_txn(1, 1, $urandom, 1, $urandom, $urandom, 4'b0011, 0, 0, $urandom);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            run_txn(r[0], r[1], $urandom, 1'($urandom_range(0, 1)), $urandom,
                    $urandom, 4'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 5), $urandom);
        end

        @(negedge clk);
        #1;
        chk_quiet("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
